cmd_receiver: RTL

- Upstream framing stage of the UART terminal.
- Consumes bytes from the UART receiver (data plus 1-cycle done strobe) and recognises the 3-byte frame HEADER, CMD, ~CMD.
- Validates the checksum and the command range, then latches the command into buff_o for the command decoder.
- Holds the commit while the downstream FSM is busy; reports framing errors and inter-byte timeouts.

---
 rtl/terminal_pkg.sv | 28 ++
 rtl/byte_timeout_timer.sv | 37 +++
 rtl/cmd_receiver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/terminal_pkg.sv
// Shared constants and types for the UART terminal framing and command stages.
// Holds frame bytes, echo codes, error causes and the receiver state encoding.
package terminal_pkg;

  localparam logic [7:0] HEADER_DEFAULT  = 8'hAA;
  localparam logic [7:0] CMD_MAX_DEFAULT = 8'h02;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_RANGE   = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitCmd = 2'd1,
    StWaitChk = 2'd2,
    StCommit  = 2'd3
  } rx_state_e;

  // The check byte is the bitwise complement of the command byte.
  function automatic logic chk_ok(input logic [7:0] cmd, input logic [7:0] chk);
    return chk == ~cmd;
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte timeout counter: clear, count-enable and a terminal-count strobe.
// tc_o fires in the cycle the count sits at TIMEOUT_CYCLES-1 while enabled.
module byte_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TermCount = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && !clr_i && (cnt_q == TermCount);

endmodule

// File: rtl/cmd_receiver.sv
// Framing stage: recognises HEADER, CMD, ~CMD, validates and commits to buff_o.
// Optional ACK/NAK echo to the UART transmitter when CMD_ECHO_EN is defined.
module cmd_receiver
  import terminal_pkg::*;
#(
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
  parameter logic [7:0]  CMD_MAX        = CMD_MAX_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 17
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_done_i,
  input  logic       busy_i,
  output logic [7:0] buff_o,
  output logic       cmd_valid_o,
  output logic       err_o,
  output logic [1:0] err_code_o
`ifdef CMD_ECHO_EN
  ,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o
`endif
);

  rx_state_e  state_q, state_d;
  logic [7:0] cmd_tmp_q, cmd_tmp_d;
  logic [7:0] buff_q, buff_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;

  logic waiting;
  logic tmr_clr;
  logic tmr_en;
  logic tmr_tc;

  // Only the two mid-frame states are timed; every accepted byte restarts the count.
  assign waiting = (state_q == StWaitCmd) || (state_q == StWaitChk);
  assign tmr_clr = rx_done_i || !waiting;
  assign tmr_en  = waiting && !rx_done_i;

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  always_comb begin
    state_d     = state_q;
    cmd_tmp_d   = cmd_tmp_q;
    buff_d      = buff_q;
    cmd_valid_d = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    unique case (state_q)
      StIdle: begin
        if (rx_done_i && (rx_data_i == HEADER)) begin
          state_d = StWaitCmd;
        end
      end
      StWaitCmd: begin
        // A repeated HEADER is taken as the command byte; no resync.
        if (rx_done_i) begin
          cmd_tmp_d = rx_data_i;
          state_d   = StWaitChk;
        end else if (tmr_tc) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = StIdle;
        end
      end
      StWaitChk: begin
        if (rx_done_i) begin
          if (!chk_ok(cmd_tmp_q, rx_data_i)) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = StIdle;
          end else if (cmd_tmp_q > CMD_MAX) begin
            err_d      = 1'b1;
            err_code_d = ERR_RANGE;
            state_d    = StIdle;
          end else begin
            state_d = StCommit;
          end
        end else if (tmr_tc) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = StIdle;
        end
      end
      StCommit: begin
        if (!busy_i) begin
          buff_d      = cmd_tmp_q;
          cmd_valid_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cmd_tmp_q   <= 8'h00;
      buff_q      <= 8'h00;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cmd_tmp_q   <= cmd_tmp_d;
      buff_q      <= buff_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign buff_o      = buff_q;
  assign cmd_valid_o = cmd_valid_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

`ifdef CMD_ECHO_EN
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_start_q, tx_start_d;

  always_comb begin
    tx_start_d = cmd_valid_d || err_d;
    tx_data_d  = tx_data_q;
    if (cmd_valid_d) begin
      tx_data_d = ACK;
    end else if (err_d) begin
      tx_data_d = NAK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
`endif

endmodule
